// File: rtl/lock_pkg.sv
// Shared types and key encoding for the password-lock input path.
// Key codes are indexed by {row, col} of the 4x4 matrix keypad.
package lock_pkg;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_PRESSED  = 2'd2
   } KeyState;

   typedef enum logic [1:0] {
      R_NONE   = 2'd0,
      R_SINGLE = 2'd1,
      R_MULTI  = 2'd2
   } ScanResult;

   // Entry 15 first: r3 = E 0 F D, r2 = 7 8 9 C, r1 = 4 5 6 B, r0 = 1 2 3 A
   localparam logic [15:0][3:0] KEY_MAP = {
      4'hD, 4'hF, 4'h0, 4'hE,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      return KEY_MAP[{r, c}];
   endfunction

   function automatic logic [2:0] count_low(input logic [3:0] rows);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) begin
         n = n + {2'b00, ~rows[i]};
      end
      return n;
   endfunction

   function automatic logic [1:0] first_low(input logic [3:0] rows);
      if (!rows[0]) begin
         return 2'd0;
      end else if (!rows[1]) begin
         return 2'd1;
      end else if (!rows[2]) begin
         return 2'd2;
      end else begin
         return 2'd3;
      end
   endfunction

endpackage

// File: rtl/input_synchronizer.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones
// so idle pulled-up lines read as inactive straight out of reset.
module input_synchronizer #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_q <= {WIDTH{1'b1}};
         sync_q <= {WIDTH{1'b1}};
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column scan, per-scan key classification,
// press/release debounce and one digitValid pulse per accepted press.
module keypad_scanner
   import lock_pkg::*;
#(
   parameter int SCAN_DIV       = 4,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] digit,
   output logic       digitValid,
   output logic       keyHeld,
   output logic       multiKey
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

   logic [3:0]       rowSync_s;
   logic [DIV_W-1:0] divCnt_q, divCnt_d;
   logic [1:0]       colIdx_q, colIdx_d;
   logic [1:0]       hitCnt_q, hitCnt_d;
   logic [3:0]       hitCode_q, hitCode_d;
   ScanResult        scanRes_q, scanRes_d;
   logic [3:0]       scanCode_q, scanCode_d;
   logic             scanDone_q, scanDone_d;
   logic             multiKey_q, multiKey_d;
   KeyState          state_q, state_d;
   logic [3:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] relCnt_q, relCnt_d;
   logic [3:0]       digit_q, digit_d;
   logic             digitValid_q, digitValid_d;
   logic             keyHeld_q, keyHeld_d;

   logic [2:0]       totRaw_s;
   logic [1:0]       total_s;
   logic [3:0]       mergedCode_s;
   logic [CNT_W-1:0] cntInc_s;
   logic [CNT_W-1:0] relInc_s;

   input_synchronizer #(.WIDTH(4)) u_row_sync (
      .clk_i  (CLK),
      .rst_ni (RST),
      .d_i    (row),
      .q_o    (rowSync_s)
   );

   // Key count saturates at 2: anything beyond one key is just "multi".
   assign totRaw_s     = {1'b0, hitCnt_q} + count_low(rowSync_s);
   assign total_s      = (totRaw_s >= 3'd2) ? 2'd2 : totRaw_s[1:0];
   assign mergedCode_s = (hitCnt_q == 2'd0) ? key_code(first_low(rowSync_s), colIdx_q) : hitCode_q;
   assign cntInc_s     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   assign relInc_s     = (relCnt_q == CNT_MAX) ? relCnt_q : relCnt_q + CNT_W'(1);

   // Column divider, row sampling and end-of-scan classification.
   always_comb begin
      divCnt_d   = divCnt_q;
      colIdx_d   = colIdx_q;
      hitCnt_d   = hitCnt_q;
      hitCode_d  = hitCode_q;
      scanRes_d  = scanRes_q;
      scanCode_d = scanCode_q;
      scanDone_d = 1'b0;
      if (scanDone_q) begin
         multiKey_d = (scanRes_q == R_MULTI);
      end else begin
         multiKey_d = multiKey_q;
      end
      if (divCnt_q == DIV_LAST) begin
         divCnt_d = '0;
         colIdx_d = colIdx_q + 2'd1;
         if (colIdx_q == 2'd3) begin
            scanDone_d = 1'b1;
            hitCnt_d   = 2'd0;
            hitCode_d  = 4'h0;
            case (total_s)
               2'd0: begin
                  scanRes_d  = R_NONE;
                  scanCode_d = 4'h0;
               end
               2'd1: begin
                  scanRes_d  = R_SINGLE;
                  scanCode_d = mergedCode_s;
               end
               default: begin
                  scanRes_d  = R_MULTI;
                  scanCode_d = 4'h0;
               end
            endcase
         end else begin
            hitCnt_d  = total_s;
            hitCode_d = mergedCode_s;
         end
      end else begin
         divCnt_d = divCnt_q + DIV_W'(1);
      end
   end

   // Debounce FSM; only moves on the cycle a scan result is registered.
   always_comb begin
      state_d      = state_q;
      cand_d       = cand_q;
      cnt_d        = cnt_q;
      relCnt_d     = relCnt_q;
      digit_d      = digit_q;
      digitValid_d = 1'b0;
      keyHeld_d    = keyHeld_q;
      if (scanDone_q) begin
         case (state_q)
            S_IDLE: begin
               if (scanRes_q == R_SINGLE) begin
                  cand_d   = scanCode_q;
                  cnt_d    = CNT_W'(1);
                  relCnt_d = '0;
                  if (DEBOUNCE_SCANS == 1) begin
                     state_d      = S_PRESSED;
                     digit_d      = scanCode_q;
                     digitValid_d = 1'b1;
                     keyHeld_d    = 1'b1;
                  end else begin
                     state_d = S_DEBOUNCE;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_DEBOUNCE: begin
               if (scanRes_q == R_SINGLE && scanCode_q == cand_q) begin
                  cnt_d = cntInc_s;
                  if (cntInc_s == CNT_MAX) begin
                     state_d      = S_PRESSED;
                     relCnt_d     = '0;
                     digit_d      = cand_q;
                     digitValid_d = 1'b1;
                     keyHeld_d    = 1'b1;
                  end else begin
                     state_d = S_DEBOUNCE;
                  end
               end else if (scanRes_q == R_SINGLE) begin
                  cand_d = scanCode_q;
                  cnt_d  = CNT_W'(1);
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            end
            S_PRESSED: begin
               if (scanRes_q == R_NONE) begin
                  relCnt_d = relInc_s;
                  if (relInc_s == CNT_MAX) begin
                     state_d   = S_IDLE;
                     relCnt_d  = '0;
                     cnt_d     = '0;
                     keyHeld_d = 1'b0;
                  end else begin
                     state_d = S_PRESSED;
                  end
               end else begin
                  relCnt_d = '0;
               end
            end
            default: begin
               state_d   = S_IDLE;
               cnt_d     = '0;
               relCnt_d  = '0;
               keyHeld_d = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         divCnt_q     <= '0;
         colIdx_q     <= 2'd0;
         hitCnt_q     <= 2'd0;
         hitCode_q    <= 4'h0;
         scanRes_q    <= R_NONE;
         scanCode_q   <= 4'h0;
         scanDone_q   <= 1'b0;
         multiKey_q   <= 1'b0;
         state_q      <= S_IDLE;
         cand_q       <= 4'h0;
         cnt_q        <= '0;
         relCnt_q     <= '0;
         digit_q      <= 4'h0;
         digitValid_q <= 1'b0;
         keyHeld_q    <= 1'b0;
      end else begin
         divCnt_q     <= divCnt_d;
         colIdx_q     <= colIdx_d;
         hitCnt_q     <= hitCnt_d;
         hitCode_q    <= hitCode_d;
         scanRes_q    <= scanRes_d;
         scanCode_q   <= scanCode_d;
         scanDone_q   <= scanDone_d;
         multiKey_q   <= multiKey_d;
         state_q      <= state_d;
         cand_q       <= cand_d;
         cnt_q        <= cnt_d;
         relCnt_q     <= relCnt_d;
         digit_q      <= digit_d;
         digitValid_q <= digitValid_d;
         keyHeld_q    <= keyHeld_d;
      end
   end

   assign col        = ~(4'b0001 << colIdx_q);
   assign digit      = digit_q;
   assign digitValid = digitValid_q;
   assign keyHeld    = keyHeld_q;
   assign multiKey   = multiKey_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural keypad matrix drives the
// rows from the scanned columns; expected values are hand-derived timings.
module tb_keypad_scanner;

   logic       CLK;
   logic       RST;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] digit;
   logic       digitValid;
   logic       keyHeld;
   logic       multiKey;

   logic [15:0] keys;
   int checks;
   int failures;
   int pulses;
   int firstp;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .row        (row),
      .col        (col),
      .digit      (digit),
      .digitValid (digitValid),
      .keyHeld    (keyHeld),
      .multiKey   (multiKey)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Pressed key (r,c) pulls row r low while column c is driven low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !col[c]) begin
               row[r] = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic run(input int n);
      pulses = 0;
      firstp = 0;
      for (int i = 1; i <= n; i++) begin
         @(negedge CLK);
         if (digitValid === 1'b1) begin
            pulses++;
            if (firstp == 0) firstp = i;
         end
      end
   endtask

   task automatic align();
      int k;
      k = 0;
      while (col !== 4'b0111 && k < 64) begin
         @(negedge CLK);
         k++;
      end
      k = 0;
      while (col !== 4'b1110 && k < 8) begin
         @(negedge CLK);
         k++;
      end
      chk("align_col", col, 4'b1110);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      keys     = 16'h0000;
      RST      = 1'b0;
      run(2);
      chk("rst_col", col, 4'b1110);
      chk("rst_digit", digit, 4'h0);
      chk("rst_valid", digitValid, 1'b0);
      chk("rst_held", keyHeld, 1'b0);
      chk("rst_multi", multiKey, 1'b0);

      RST = 1'b1;
      run(4);
      chk("scan_col1", col, 4'b1101);
      run(4);
      chk("scan_col2", col, 4'b1011);
      run(4);
      chk("scan_col3", col, 4'b0111);
      run(4);
      chk("scan_col0", col, 4'b1110);

      // Clean press of r2c2 (digit 9) for 5 scans, then release.
      align();
      keys[2*4+2] = 1'b1;
      run(80);
      chk("clean_pulses", pulses, 1);
      chk("clean_latency", firstp, 49);
      chk("clean_digit", digit, 4'h9);
      chk("clean_held", keyHeld, 1'b1);
      keys = 16'h0000;
      run(48);
      chk("clean_rel_pulses", pulses, 0);
      chk("clean_held_2rel", keyHeld, 1'b1);
      run(1);
      chk("clean_held_clr", keyHeld, 1'b0);

      // Bounce on r0c1 (digit 2), toggling every 10 cycles, then held.
      align();
      keys[1] = 1'b1;
      run(10);
      chk("bounce_p1", pulses, 0);
      keys[1] = 1'b0;
      run(10);
      chk("bounce_p2", pulses, 0);
      keys[1] = 1'b1;
      run(10);
      chk("bounce_p3", pulses, 0);
      keys[1] = 1'b0;
      run(10);
      chk("bounce_p4", pulses, 0);
      keys[1] = 1'b1;
      run(80);
      chk("bounce_pulses", pulses, 1);
      chk("bounce_latency", firstp, 57);
      chk("bounce_digit", digit, 4'h2);
      keys = 16'h0000;
      run(80);
      chk("bounce_rel_held", keyHeld, 1'b0);

      // Two keys r3c1 + r0c0, then drop r0c0 leaving digit 0.
      align();
      keys[3*4+1] = 1'b1;
      keys[0]     = 1'b1;
      run(16);
      chk("multi_before", multiKey, 1'b0);
      chk("multi_p1", pulses, 0);
      run(1);
      chk("multi_set", multiKey, 1'b1);
      run(31);
      chk("multi_p2", pulses, 0);
      keys[0] = 1'b0;
      run(49);
      chk("multi_rel_pulses", pulses, 1);
      chk("multi_rel_latency", firstp, 49);
      chk("multi_rel_digit", digit, 4'h0);
      chk("multi_clr", multiKey, 1'b0);
      keys = 16'h0000;
      run(80);
      chk("multi_end_held", keyHeld, 1'b0);

      // Rollover: 5 accepted, add 6, drop 5, drop 6, re-press 6.
      align();
      keys[1*4+1] = 1'b1;
      run(49);
      chk("roll_p5", pulses, 1);
      chk("roll_lat5", firstp, 49);
      chk("roll_digit5", digit, 4'h5);
      keys[1*4+2] = 1'b1;
      run(48);
      chk("roll_add6_pulses", pulses, 0);
      chk("roll_add6_multi", multiKey, 1'b1);
      keys[1*4+1] = 1'b0;
      run(64);
      chk("roll_drop5_pulses", pulses, 0);
      chk("roll_drop5_held", keyHeld, 1'b1);
      chk("roll_drop5_digit", digit, 4'h5);
      keys = 16'h0000;
      run(80);
      chk("roll_empty_pulses", pulses, 0);
      chk("roll_empty_held", keyHeld, 1'b0);
      align();
      keys[1*4+2] = 1'b1;
      run(49);
      chk("roll_p6", pulses, 1);
      chk("roll_lat6", firstp, 49);
      chk("roll_digit6", digit, 4'h6);

      // Reset while 6 is still held in the pressed state.
      RST = 1'b0;
      run(1);
      chk("midrst_held", keyHeld, 1'b0);
      chk("midrst_digit", digit, 4'h0);
      chk("midrst_col", col, 4'b1110);
      chk("midrst_valid", digitValid, 1'b0);
      RST = 1'b1;
      run(49);
      chk("midrst_pulses", pulses, 1);
      chk("midrst_latency", firstp, 49);
      chk("midrst_digit6", digit, 4'h6);
      chk("midrst_held6", keyHeld, 1'b1);
      keys = 16'h0000;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream input stage for the serial password lock. It scans a 4x4 active-low matrix keypad, debounces it and encodes the pressed key to a 4-bit digit.
- It emits exactly one single-cycle `digitValid` pulse per physical key press.
- Downstream, the lock consumes `digit` qualified by `digitValid`; this stage is what replaces the raw manual-clock digit entry.

Parameters:
- SCAN_DIV, 4: clock cycles each column is driven. Must be >= 4 to cover the 2-flop sync latency plus settling.
- DEBOUNCE_SCANS, 3: consecutive identical full-scan results needed to accept a press, and consecutive empty scans needed to accept a release. Must be >= 1.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST  input  1  reset. Synchronous, active-low: sampled only on the CLK rising edge, asserted when 0.
- row  input  4  keypad rows, active-low, externally pulled up, asynchronous to CLK.
- col  output 4  column drive, active-low one-hot; exactly one bit is 0 at all times.
- digit  output 4  last accepted key code; holds until the next acceptance.
- digitValid  output 1  single-cycle pulse marking a newly accepted key.
- keyHeld  output 1  high while an accepted key has not yet been debounced as released.
- multiKey  output 1  high while the most recent completed scan saw more than one key down.

Behaviour:
- Reset values (RST=0 at a rising edge): col=4'b1110, divCnt=0, colIdx=0, digit=0, digitValid=0, keyHeld=0, multiKey=0, FSM=S_IDLE, all counters 0, sync flops 4'b1111.
- Reset mid-press aborts everything. After reset, a still-held key must pass full debounce again before it is accepted.
- Synchronizer: `row` goes through 2 flops to give rowSync.
- Scan timing:
  - divCnt counts 0..SCAN_DIV-1 and wraps.
  - colIdx (2 bits) increments when divCnt wraps and wraps 3 to 0.
  - col = ~(1<<colIdx).
  - rowSync is sampled at divCnt==SCAN_DIV-1, so one scan takes 4*SCAN_DIV cycles.
- Scan accumulation:
  - Each sampled low row bit counts as one key at (rowIdx, colIdx).
  - The scan result, registered at the end of colIdx=3, is R_NONE (0 keys), R_SINGLE with a code (1 key), or R_MULTI (>=2 keys).
  - Accumulators clear for the next scan in the same cycle.
- Key code map, row r and col c:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- multiKey is updated once per scan from the registered result.
- FSM advances only on the cycle a scan result is registered (scanDone).
- S_IDLE:
  - R_SINGLE(K): go to S_DEBOUNCE, cand=K, cnt=1.
  - If DEBOUNCE_SCANS==1, go to S_PRESSED instead and accept immediately.
- S_DEBOUNCE:
  - R_SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_SCANS, go to S_PRESSED and accept.
  - R_SINGLE(other): restart with cand=new key, cnt=1.
  - R_NONE or R_MULTI: go to S_IDLE.
- Accept: digit<=cand and digitValid=1 for exactly the one cycle after scanDone. keyHeld=1 from the same cycle.
- S_PRESSED:
  - R_NONE: relCnt+1. When relCnt reaches DEBOUNCE_SCANS, go to S_IDLE and clear keyHeld.
  - Any other result: relCnt=0 and stay. Second keys, rollover and bounce never produce a pulse.
- Latency: a key stable from the start of a scan gives digitValid 1 cycle after the end of the DEBOUNCE_SCANS-th scan, i.e. DEBOUNCE_SCANS*4*SCAN_DIV+1 cycles.
- Counter widths: divCnt $clog2(SCAN_DIV); cnt and relCnt $clog2(DEBOUNCE_SCANS+1). Counters saturate and never wrap.

Decomposition:
- lock_pkg holds the KeyState enum {S_IDLE, S_DEBOUNCE, S_PRESSED}, the ScanResult enum {R_NONE, R_SINGLE, R_MULTI}, and the constant 16-entry key-map array. The lock modules share lock_pkg.
- One sub-module, input_synchronizer: a parameterised-width 2-flop synchronizer with synchronous active-low reset value all-ones.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, scan = 16 cycles):
- Reset: RST=0 for 2 cycles, rows idle -> col=1110, digit=0, all flags 0. After release, col cycles 1110/1101/1011/0111 every 4 cycles.
- Clean press of r2c2, held 5 scans, then released -> digit=9, exactly one digitValid pulse 49 cycles after aligned scan start. keyHeld clears 3 empty scans after release.
- Bounce: r0c1 toggled every 10 cycles for 40 cycles, then held -> no pulse during bounce, one pulse with digit=2 after 3 stable scans.
- Two keys r3c1+r0c0 held -> multiKey=1 after the first scan, no digitValid. Release r0c0 -> digit=0 accepted after 3 scans.
- Rollover: hold 5 (accepted), then add 6, then release 5 -> no second pulse until all keys are empty for 3 scans and 6 is re-pressed.
- Reset mid-press: RST=0 pulsed during S_PRESSED with the key still held -> keyHeld=0 at once, and a fresh pulse appears 3 scans after reset.
